// File: rtl/rob_commit_unit.sv
// In-order reorder buffer: allocates rename tags 1..7, collects writebacks,
// answers operand queries and retires one entry per cycle to the regfile.
//
// Ports: clk, rst (async active-low); issue_valid/issue_rd -> issue_ready,
// issue_tag; wb_valid/wb_tag/wb_data; query1/2_tag -> query1/2_ready,
// query1/2_value; commit, reg_num, data_in, num_in, count (registered).
// Optional macro WB_BYPASS_EN: forward same-cycle writeback data to queries.
module rob_commit_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            issue_ready,
  output logic [2:0]      issue_tag,
  input  logic            wb_valid,
  input  logic [2:0]      wb_tag,
  input  logic [XLEN-1:0] wb_data,
  input  logic [2:0]      query1_tag,
  input  logic [2:0]      query2_tag,
  output logic            query1_ready,
  output logic            query2_ready,
  output logic [XLEN-1:0] query1_value,
  output logic [XLEN-1:0] query2_value,
  output logic            commit,
  output logic [4:0]      reg_num,
  output logic [XLEN-1:0] data_in,
  output logic [2:0]      num_in,
  output logic [2:0]      count
);

  localparam int DEPTH = 7;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] done;
  logic [4:0]       rd_q   [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  logic [2:0]       head;
  logic [2:0]       tail;

  logic [2:0] wb_idx;
  logic       wb_hit;
  logic       retire;
  logic       issue_fire;

  function automatic logic [2:0] wrap_inc(input logic [2:0] p);
    return (p == 3'd6) ? 3'd0 : p + 3'd1;
  endfunction

  // Tag t lives in entry t-1; tag 0 never hits.
  function automatic logic [XLEN:0] lookup(input logic [2:0] t);
    logic [2:0] i;
    i = t - 3'd1;
    lookup = '0;
    if (t != 3'd0 && busy[i] && done[i])
      lookup = {1'b1, data_q[i]};
`ifdef WB_BYPASS_EN
    if (t != 3'd0 && busy[i] && wb_valid && wb_tag == t)
      lookup = {1'b1, wb_data};
`endif
  endfunction

  assign issue_ready = (count != 3'd7);
  assign issue_tag   = tail + 3'd1;
  assign issue_fire  = issue_valid && issue_ready;
  assign wb_idx      = wb_tag - 3'd1;
  assign wb_hit      = wb_valid && (wb_tag != 3'd0) && busy[wb_idx];
  assign retire      = (count != 3'd0) && done[head];

  always_comb begin
    {query1_ready, query1_value} = lookup(query1_tag);
  end

  always_comb begin
    {query2_ready, query2_value} = lookup(query2_tag);
  end

  // Later assignments win: a retire clears its entry even if a repeated
  // writeback to the same tag lands on that edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy    <= '0;
      done    <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      commit  <= 1'b0;
      reg_num <= '0;
      data_in <= '0;
      num_in  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      commit <= 1'b0;
      if (wb_hit) begin
        done[wb_idx]   <= 1'b1;
        data_q[wb_idx] <= wb_data;
      end
      if (retire) begin
        commit     <= (rd_q[head] != 5'd0);
        reg_num    <= rd_q[head];
        data_in    <= data_q[head];
        num_in     <= head + 3'd1;
        busy[head] <= 1'b0;
        done[head] <= 1'b0;
        head       <= wrap_inc(head);
      end
      if (issue_fire) begin
        busy[tail] <= 1'b1;
        done[tail] <= 1'b0;
        rd_q[tail] <= issue_rd;
        tail       <= wrap_inc(tail);
      end
      unique case ({issue_fire, retire})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Testbench for rob_commit_unit: queue-based reference model compared every
// cycle, plus hand-computed literal expectations for the directed scenarios.
module tb_rob_commit_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            issue_ready;
  logic [2:0]      issue_tag;
  logic            wb_valid;
  logic [2:0]      wb_tag;
  logic [XLEN-1:0] wb_data;
  logic [2:0]      query1_tag;
  logic [2:0]      query2_tag;
  logic            query1_ready;
  logic            query2_ready;
  logic [XLEN-1:0] query1_value;
  logic [XLEN-1:0] query2_value;
  logic            commit;
  logic [4:0]      reg_num;
  logic [XLEN-1:0] data_in;
  logic [2:0]      num_in;
  logic [2:0]      count;

  always #5 clk = ~clk;

  rob_commit_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .issue_tag(issue_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .query1_tag(query1_tag), .query2_tag(query2_tag),
    .query1_ready(query1_ready), .query2_ready(query2_ready),
    .query1_value(query1_value), .query2_value(query2_value),
    .commit(commit), .reg_num(reg_num), .data_in(data_in),
    .num_in(num_in), .count(count)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: program-order queue of tags plus per-tag records.
  int          mq[$];
  bit          mb[8];
  bit          md[8];
  logic [4:0]  mr[8];
  logic [31:0] mdat[8];
  int          mnext;
  logic        m_commit;
  logic [4:0]  m_reg;
  logic [31:0] m_din;
  logic [2:0]  m_num;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  function automatic void m_reset();
    mq.delete();
    for (int i = 0; i < 8; i++) begin
      mb[i] = 0; md[i] = 0; mr[i] = 0; mdat[i] = 0;
    end
    mnext = 1;
    m_commit = 0; m_reg = 0; m_din = 0; m_num = 0;
  endfunction

  function automatic bit exp_ready(logic [2:0] t);
    if (t == 0) return 0;
`ifdef WB_BYPASS_EN
    if (wb_valid && wb_tag == t && mb[t]) return 1;
`endif
    return mb[t] && md[t];
  endfunction

  function automatic logic [31:0] exp_value(logic [2:0] t);
    if (t == 0) return 0;
`ifdef WB_BYPASS_EN
    if (wb_valid && wb_tag == t && mb[t]) return wb_data;
`endif
    if (mb[t] && md[t]) return mdat[t];
    return 0;
  endfunction

  function automatic void model_step();
    int  pre;
    int  t;
    bit  ret;
    pre = mq.size();
    ret = (pre > 0) && md[mq[0]];
    if (wb_valid && wb_tag != 0 && mb[wb_tag]) begin
      md[wb_tag] = 1;
      mdat[wb_tag] = wb_data;
    end
    m_commit = 0;
    if (ret) begin
      t = mq.pop_front();
      m_commit = (mr[t] != 0);
      m_reg = mr[t];
      m_din = mdat[t];
      m_num = 3'(t);
      mb[t] = 0;
      md[t] = 0;
    end
    if (issue_valid && pre < 7) begin
      mq.push_back(mnext);
      mb[mnext] = 1;
      md[mnext] = 0;
      mr[mnext] = issue_rd;
      mnext = (mnext == 7) ? 1 : mnext + 1;
    end
  endfunction

  task automatic check_comb();
    chk("count", 32'(count), 32'(mq.size()));
    chk("issue_ready", 32'(issue_ready), 32'(mq.size() < 7));
    if (mq.size() < 7) chk("issue_tag", 32'(issue_tag), 32'(mnext));
    chk("q1_ready", 32'(query1_ready), 32'(exp_ready(query1_tag)));
    chk("q1_value", query1_value, exp_value(query1_tag));
    chk("q2_ready", 32'(query2_ready), 32'(exp_ready(query2_tag)));
    chk("q2_value", query2_value, exp_value(query2_tag));
  endtask

  task automatic check_all();
    check_comb();
    chk("commit", 32'(commit), 32'(m_commit));
    chk("reg_num", 32'(reg_num), 32'(m_reg));
    chk("data_in", data_in, m_din);
    chk("num_in", 32'(num_in), 32'(m_num));
  endtask

  task automatic tick();
    #1;
    check_comb();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic cyc(logic iv, logic [4:0] rd, logic wv,
                     logic [2:0] wt, logic [31:0] wd);
    issue_valid = iv;
    issue_rd = rd;
    wb_valid = wv;
    wb_tag = wt;
    wb_data = wd;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    issue_valid = 0; wb_valid = 0; wb_tag = 0; wb_data = 0; issue_rd = 0;
    m_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    issue_valid = 0; issue_rd = 0;
    wb_valid = 0; wb_tag = 0; wb_data = 0;
    query1_tag = 0; query2_tag = 0;
    m_reset();
    #2;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_commit", 32'(commit), 0);
    chk("rst_ready", 32'(issue_ready), 1);
    chk("rst_tag", 32'(issue_tag), 1);

    // Fill, overflow attempt, then drain.
    query1_tag = 3'd3;
    query2_tag = 3'd7;
    for (int i = 1; i <= 7; i++) begin
      chk("alloc_tag", 32'(issue_tag), 32'(i));
      cyc(1, 5'(i), 0, 0, 0);
    end
    chk("full_ready", 32'(issue_ready), 0);
    chk("full_count", 32'(count), 7);
    cyc(1, 5'd9, 0, 0, 0);
    chk("full_ignored", 32'(count), 7);
    for (int i = 1; i <= 7; i++)
      cyc(0, 0, 1, 3'(i), 32'(i) * 32'h1111_1111);
    for (int i = 0; i < 20 && count != 0; i++)
      cyc(0, 0, 0, 0, 0);
    chk("drain", 32'(count), 0);

    // Writeback-to-commit latency.
    do_reset();
    cyc(1, 5'd5, 0, 0, 0);
    cyc(0, 0, 1, 3'd1, 32'hDEAD_BEEF);
    chk("lat_edge_n", 32'(commit), 0);
    cyc(0, 0, 0, 0, 0);
    chk("lat_commit", 32'(commit), 1);
    chk("lat_reg", 32'(reg_num), 5);
    chk("lat_data", data_in, 32'hDEAD_BEEF);
    chk("lat_num", 32'(num_in), 1);
    cyc(0, 0, 0, 0, 0);
    chk("lat_pulse_end", 32'(commit), 0);

    // Out-of-order writebacks, in-order retirement.
    do_reset();
    cyc(1, 5'd10, 0, 0, 0);
    cyc(1, 5'd11, 0, 0, 0);
    cyc(1, 5'd12, 0, 0, 0);
    cyc(0, 0, 1, 3'd3, 32'hC3);
    chk("ooo_wait3", 32'(commit), 0);
    cyc(0, 0, 1, 3'd2, 32'hC2);
    chk("ooo_wait2", 32'(commit), 0);
    cyc(0, 0, 1, 3'd1, 32'hC1);
    chk("ooo_wait1", 32'(commit), 0);
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("ooo_commit", 32'(commit), 1);
      chk("ooo_num", 32'(num_in), 32'(i));
    end
    cyc(0, 0, 0, 0, 0);
    chk("ooo_done", 32'(commit), 0);
    chk("ooo_empty", 32'(count), 0);

    // Full boundary, tag wrap and simultaneous issue+retire.
    do_reset();
    for (int i = 1; i <= 7; i++)
      cyc(1, 5'(i), 0, 0, 0);
    cyc(0, 0, 1, 3'd1, 32'hA1);
    cyc(1, 5'd20, 0, 0, 0);
    chk("wrap_blocked", 32'(count), 6);
    chk("wrap_ret_num", 32'(num_in), 1);
    chk("wrap_tag", 32'(issue_tag), 1);
    cyc(1, 5'd20, 0, 0, 0);
    chk("wrap_refill", 32'(count), 7);
    cyc(0, 0, 1, 3'd2, 32'hA2);
    cyc(0, 0, 0, 0, 0);
    chk("wrap_ret2", 32'(count), 6);
    cyc(0, 0, 1, 3'd3, 32'hA3);
    cyc(1, 5'd21, 0, 0, 0);
    chk("iss_ret_count", 32'(count), 6);
    chk("iss_ret_num", 32'(num_in), 3);
    chk("iss_ret_data", data_in, 32'hA3);

    // Operand queries.
    do_reset();
    query1_tag = 3'd2;
    query2_tag = 3'd0;
    cyc(1, 5'd1, 0, 0, 0);
    cyc(1, 5'd2, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("qry_before", 32'(query1_ready), 0);
    wb_valid = 1; wb_tag = 3'd2; wb_data = 32'h1234;
    #1;
`ifdef WB_BYPASS_EN
    chk("qry_bypass_rdy", 32'(query1_ready), 1);
    chk("qry_bypass_val", query1_value, 32'h1234);
`else
    chk("qry_same_rdy", 32'(query1_ready), 0);
    chk("qry_same_val", query1_value, 0);
`endif
    tick();
    chk("qry_after_rdy", 32'(query1_ready), 1);
    chk("qry_after_val", query1_value, 32'h1234);
    chk("qry_tag0", 32'(query2_ready), 0);
    query2_tag = 3'd5;
    cyc(0, 0, 1, 3'd0, 32'hBAD);
    cyc(0, 0, 1, 3'd5, 32'hBAD);
    chk("qry_nonbusy", 32'(query2_ready), 0);
    chk("qry_kept", query1_value, 32'h1234);
    cyc(0, 0, 1, 3'd2, 32'h5678);
    chk("qry_overwrite", query1_value, 32'h5678);
    chk("qry_no_commit", 32'(commit), 0);

    // Reset mid-operation, then an rd=0 retire.
    do_reset();
    for (int i = 1; i <= 4; i++)
      cyc(1, 5'(i), 0, 0, 0);
    cyc(0, 0, 1, 3'd1, 32'h77);
    wb_valid = 1; wb_tag = 3'd2; wb_data = 32'h88;
    #2;
    rst = 1'b0;
    m_reset();
    #1;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_commit", 32'(commit), 0);
    chk("mid_rst_tag", 32'(issue_tag), 1);
    @(posedge clk);
    #1;
    check_all();
    wb_valid = 0;
    rst = 1'b1;
    #1;
    cyc(0, 0, 0, 0, 0);
    chk("post_rst_commit", 32'(commit), 0);
    chk("post_rst_tag", 32'(issue_tag), 1);
    cyc(1, 5'd0, 0, 0, 0);
    cyc(0, 0, 1, 3'd1, 32'h99);
    cyc(0, 0, 0, 0, 0);
    chk("x0_commit", 32'(commit), 0);
    chk("x0_num", 32'(num_in), 1);
    chk("x0_reg", 32'(reg_num), 0);
    chk("x0_data", data_in, 32'h99);
    chk("x0_count", 32'(count), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
